// File: rtl/interleaver_ctrl.sv
// Convolutional (Forney) interleaver controller.
// Time-shares one external read-first single-port RAM across BRANCHES delay
// lines. Branch b owns a circular region of b*DEPTH bytes starting at
// base(b) = DEPTH*b*(b-1)/2, so the regions pack back to back with no gaps.
// Branch 0 is a pass-through and never touches the RAM.
module interleaver_ctrl #(
  parameter int BRANCHES = 12,
  parameter int DEPTH    = 17,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upstream_rdy,
  input  logic [7:0]        upstream_data,
  input  logic              upstream_sync,
  output logic              upstream_acpt,
  output logic              downstream_rdy,
  output logic [7:0]        downstream_data,
  input  logic              downstream_acpt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              init_done
);

  localparam int RAM_SIZE = DEPTH * BRANCHES * (BRANCHES - 1) / 2;
  localparam int BR_W     = (BRANCHES > 2) ? $clog2(BRANCHES) : 1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_MEM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [BR_W-1:0]   comm_r;
  logic [BR_W-1:0]   br_r;
  logic [BR_W-1:0]   br_sel_s;
  logic [7:0]        byte_r;
  logic [7:0]        dout_r;
  logic              init_done_r;
  logic [ADDR_W-1:0] ptr_r [BRANCHES];

  // First RAM word of branch b's circular delay region.
  function automatic logic [ADDR_W-1:0] base_addr(input logic [BR_W-1:0] b);
    int bi;
    bi = int'(b);
    return ADDR_W'(DEPTH * bi * (bi - 1) / 2);
  endfunction

  // Last valid pointer value of branch b before it wraps back to 0.
  function automatic logic [ADDR_W-1:0] ptr_last(input logic [BR_W-1:0] b);
    int bi;
    bi = int'(b);
    return ADDR_W'(bi * DEPTH - 1);
  endfunction

  assign downstream_rdy  = (state_r == S_OUT);
  assign downstream_data = dout_r;
  assign init_done       = init_done_r;

  // Next-state logic plus the same-cycle RAM port and upstream acceptance.
  always_comb begin
    state_s       = state_r;
    upstream_acpt = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = 8'h00;
    if (upstream_sync) begin
      br_sel_s = '0;
    end else begin
      br_sel_s = comm_r;
    end
    if (reset) begin
      state_s = S_INIT;
    end else begin
      case (state_r)
        S_INIT: begin
          ram_we   = 1'b1;
          ram_addr = clr_cnt_r;
          if (clr_cnt_r == ADDR_W'(RAM_SIZE - 1)) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_INIT;
          end
        end
        S_IDLE: begin
          upstream_acpt = 1'b1;
          if (upstream_rdy) begin
            state_s = S_MEM;
            // Write the new byte; the read-first RAM returns the oldest byte
            // of this branch on the following cycle.
            if (br_sel_s != '0) begin
              ram_we    = 1'b1;
              ram_addr  = base_addr(br_sel_s) + ptr_r[br_sel_s];
              ram_wdata = upstream_data;
            end else begin
              ram_we = 1'b0;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_MEM: begin
          state_s = S_OUT;
        end
        S_OUT: begin
          if (downstream_acpt) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_OUT;
          end
        end
        default: begin
          state_s = S_INIT;
        end
      endcase
    end
  end

  // State register, clear counter, branch pointers, commutator and output byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_INIT;
      clr_cnt_r   <= '0;
      comm_r      <= '0;
      br_r        <= '0;
      byte_r      <= 8'h00;
      dout_r      <= 8'h00;
      init_done_r <= 1'b0;
      for (int i = 0; i < BRANCHES; i++) begin
        ptr_r[i] <= '0;
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        S_INIT: begin
          clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          if (clr_cnt_r == ADDR_W'(RAM_SIZE - 1)) begin
            init_done_r <= 1'b1;
          end
        end
        S_IDLE: begin
          if (upstream_rdy) begin
            br_r   <= br_sel_s;
            byte_r <= upstream_data;
          end
        end
        S_MEM: begin
          if (br_r != '0) begin
            dout_r <= ram_rdata;
            if (ptr_r[br_r] == ptr_last(br_r)) begin
              ptr_r[br_r] <= '0;
            end else begin
              ptr_r[br_r] <= ptr_r[br_r] + ADDR_W'(1);
            end
          end else begin
            dout_r <= byte_r;
          end
          // A sync byte realigns the commutator: the next byte lands on branch 1.
          if (br_r == BR_W'(BRANCHES - 1)) begin
            comm_r <= '0;
          end else begin
            comm_r <= br_r + BR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Bench for interleaver_ctrl with a small geometry (3 branches, depth 2).
// Reference: one FIFO per branch pre-filled with b*DEPTH zeros; each byte is
// pushed to its branch and the byte popped is the expected output.
module tb_interleaver_ctrl;

  localparam int B  = 3;
  localparam int D  = 2;
  localparam int AW = 3;
  localparam int RS = D * B * (B - 1) / 2;

  logic          clk;
  logic          reset;
  logic          upstream_rdy;
  logic [7:0]    upstream_data;
  logic          upstream_sync;
  logic          upstream_acpt;
  logic          downstream_rdy;
  logic [7:0]    downstream_data;
  logic          downstream_acpt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          init_done;

  interleaver_ctrl #(.BRANCHES(B), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .upstream_rdy(upstream_rdy), .upstream_data(upstream_data),
    .upstream_sync(upstream_sync), .upstream_acpt(upstream_acpt),
    .downstream_rdy(downstream_rdy), .downstream_data(downstream_data),
    .downstream_acpt(downstream_acpt),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .init_done(init_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External read-first RAM, power-up contents deliberately non-zero.
  logic [7:0] mem [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hA5 ^ 8'(i);
  end
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ---------------- reference model and compare process ----------------
  logic [7:0] bq [B][$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         hs_cyc [$];
  int  comm_m, init_cnt, since, cyc, stall_cnt;
  bit  run, pending, rst_seen, log_en, stall_watch;
  bit  prev_rdy, prev_acpt;
  logic [7:0] prev_data;

  function automatic int base_of(input int b);
    return D * b * (b - 1) / 2;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < B; b++) begin
      bq[b].delete();
      for (int k = 0; k < b * D; k++) bq[b].push_back(8'h00);
    end
    exp_q.delete();
    comm_m = 0; init_cnt = 0; since = 0;
    run = 0; pending = 0; prev_rdy = 0; prev_acpt = 0; prev_data = 8'h00;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int b;
    logic [7:0] e;
    cyc++;
    if (reset) begin
      model_reset();
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_dn_rdy", int'(downstream_rdy), 0);
        chk("rst_dn_data", int'(downstream_data), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_up_acpt", int'(upstream_acpt), 0);
        rst_seen = 0;
      end
      if (!run) begin
        if (init_cnt < RS) begin
          chk("init_we", int'(ram_we), 1);
          chk("init_addr", int'(ram_addr), init_cnt);
          chk("init_wdata", int'(ram_wdata), 0);
          chk("init_acpt", int'(upstream_acpt), 0);
          chk("init_done_early", int'(init_done), 0);
          chk("init_dn_rdy", int'(downstream_rdy), 0);
        end else begin
          chk("init_done_rise", int'(init_done), 1);
          run = 1;
        end
        init_cnt++;
      end
      if (run) begin
        if (pending) since++;
        chk("init_done_hold", int'(init_done), 1);
        chk("up_acpt", int'(upstream_acpt), int'(!pending));
        chk("dn_rdy", int'(downstream_rdy), int'(pending && since >= 2));
        if (prev_rdy && !prev_acpt) begin
          chk("hold_rdy", int'(downstream_rdy), 1);
          chk("hold_data", int'(downstream_data), int'(prev_data));
        end
        if (stall_watch && downstream_rdy && !downstream_acpt && downstream_data == 8'h04)
          stall_cnt++;
        if (downstream_rdy && downstream_acpt) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("dn_data", int'(downstream_data), int'(e));
          end
          if (log_en) got_q.push_back(downstream_data);
          pending = 0;
        end
        if (upstream_rdy && upstream_acpt) begin
          b = upstream_sync ? 0 : comm_m;
          bq[b].push_back(upstream_data);
          exp_q.push_back(bq[b].pop_front());
          comm_m = (b + 1) % B;
          if (b != 0) begin
            chk("wr_we", int'(ram_we), 1);
            chk("wr_data", int'(ram_wdata), int'(upstream_data));
            chk("wr_addr_lo", int'(int'(ram_addr) >= base_of(b)), 1);
            chk("wr_addr_hi", int'(int'(ram_addr) < base_of(b) + b * D), 1);
          end else begin
            chk("bypass_no_we", int'(ram_we), 0);
          end
          if (log_en) hs_cyc.push_back(cyc);
          pending = 1;
          since = 0;
        end else begin
          chk("idle_no_we", int'(ram_we), 0);
        end
        prev_rdy  = downstream_rdy;
        prev_acpt = downstream_acpt;
        prev_data = downstream_data;
      end
    end
  end

  // ---------------- consumer ----------------
  int acpt_mode = 0;
  bit stall_arm = 0;
  initial begin
    downstream_acpt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (acpt_mode)
        0: downstream_acpt = 1'b1;
        1: downstream_acpt = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_arm && downstream_rdy && downstream_data == 8'h04) begin
            downstream_acpt = 1'b0;
            repeat (10) begin
              @(posedge clk);
              #1;
            end
            stall_arm = 0;
          end
          downstream_acpt = 1'b1;
        end
        3: downstream_acpt = !(downstream_rdy && downstream_data == 8'h07);
        default: downstream_acpt = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic s);
    int  guard;
    bit  hs;
    upstream_rdy  = 1'b1;
    upstream_data = d;
    upstream_sync = s;
    guard = 0;
    hs = 0;
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = upstream_acpt;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!hs) chk("send_timeout", 0, 1);
    upstream_rdy  = 1'b0;
    upstream_sync = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_init();
    int g = 0;
    while (!init_done && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("init_timeout", int'(init_done), 1);
  endtask

  task automatic wait_outputs(input int n);
    int g = 0;
    while (got_q.size() < n && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("output_timeout", int'(got_q.size() >= n), 1);
  endtask

  task automatic drain();
    int g = 0;
    while ((pending || exp_q.size() != 0) && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_timeout", int'(pending), 0);
  endtask

  logic [7:0] lit [16] = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h07, 8'h02,
                          8'h00, 8'h0A, 8'h05, 8'h00, 8'h0D, 8'h08, 8'h03, 8'h10};

  task automatic check_literal_stream(input string tag);
    for (int i = 0; i < 16; i++)
      chk({tag, "_lit"}, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(lit[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    upstream_rdy = 1'b0;
    upstream_data = 8'h00;
    upstream_sync = 1'b0;
    cyc = 0;
    stall_cnt = 0;
    log_en = 0;
    stall_watch = 0;

    // Fresh start, stream 0x01..0x10 with a 10-cycle stall on byte 0x04.
    do_reset();
    wait_init();
    acpt_mode = 2;
    stall_arm = 1;
    stall_watch = 1;
    log_en = 1;
    got_q.delete();
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    wait_outputs(16);
    check_literal_stream("stall_run");
    chk("stall_cycles", stall_cnt, 10);
    stall_watch = 0;

    // Sync on a commutator-2 slot: 0x11 takes branch 1, 0xAA is forced to
    // branch 0 and passes unchanged, then 0x12 is on branch 1 again.
    acpt_mode = 0;
    got_q.delete();
    send(8'h11, 1'b0);
    send(8'hAA, 1'b1);
    send(8'h12, 1'b0);
    wait_outputs(3);
    chk("sync_out_aa", int'(got_q[1]), 8'hAA);
    chk("after_sync_branch1", int'(got_q[2]), 8'h0E);

    // Reset while holding 0x07 in the output stage, then rerun the stream.
    do_reset();
    wait_init();
    acpt_mode = 3;
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    begin
      int g = 0;
      while (!(downstream_rdy && downstream_data == 8'h07) && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      chk("hold_07_seen", int'(downstream_rdy && downstream_data == 8'h07), 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acpt_mode = 0;
    wait_init();
    got_q.delete();
    hs_cyc.delete();
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    wait_outputs(16);
    check_literal_stream("post_reset");
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("throughput_3cyc", hs_cyc[i] - hs_cyc[i-1], 3);
    log_en = 0;

    // Randomised traffic: random bytes, occasional sync, gaps and stalls.
    acpt_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
